// File: rtl/flab_pkg.sv
// flab_pkg: shared geometry, state and column types for the obstacle generator
package flab_pkg;
  localparam int ROWS = 24;
  localparam int GAP_H = 6;
  localparam int MARGIN = 2;
  localparam int MAX_TRIES = 8;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [4:0] GAP_MIN = 5'(MARGIN);
  localparam logic [4:0] GAP_MAX = 5'(ROWS - GAP_H - MARGIN);
  localparam logic [4:0] GAP_FALLBACK = 5'((ROWS - GAP_H) / 2);
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  typedef enum logic [1:0] {G_IDLE, G_DRAW, G_BUILD, G_COMMIT} gen_state_t;
  typedef logic [ROWS-1:0] column_t;
  typedef column_t [1:0] pair_t;
endpackage

// File: rtl/obstacle_generator_if.sv
// obstacle_generator_if: request/pattern link between the scroller and the generator
interface obstacle_generator_if;
  import flab_pkg::*;
  logic req_slot1;
  logic req_slot0;
  pair_t obst1;
  pair_t obst0;
  logic valid1;
  logic valid0;
  logic busy;
  logic [4:0] gap_pos1;
  logic [4:0] gap_pos0;
  modport master (
    output req_slot1, req_slot0,
    input obst1, obst0, valid1, valid0, busy, gap_pos1, gap_pos0
  );
  modport slave (
    input req_slot1, req_slot0,
    output obst1, obst0, valid1, valid0, busy, gap_pos1, gap_pos0
  );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, a zero seed is replaced by 1
module lfsr16
  import flab_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  logic [15:0] state_q, state_d;
  // shift right, folding the feedback taps in when a one drops out
  always_comb state_d = state_q[0] ? (state_q >> 1) ^ LFSR_MASK : state_q >> 1;
  // state register, advances every cycle out of reset
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= INIT;
    else state_q <= state_d;
  assign state = state_q;
endmodule

// File: rtl/obstacle_generator.sv
// obstacle_generator: draws gapped wall column pairs for two scroller slots on request
module obstacle_generator
  import flab_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic reset,
  obstacle_generator_if.slave bus
);
  if (ROWS - GAP_H - MARGIN > 31) begin : g_geom_check
    $error("gap window does not fit a 5-bit gap position");
  end
  logic [15:0] lfsr;
  logic unused_lfsr;
  logic [4:0] cand;
  logic cand_ok, edge1, edge0, commit1, commit0;
  column_t mask;
  gen_state_t state_q, state_d;
  logic tgt_q, tgt_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [4:0] gap_q, gap_d;
  column_t col_q, col_d;
  logic req1_q, req1_d, req0_q, req0_d;
  logic pend1_q, pend1_d, pend0_q, pend0_d;
  pair_t obst1_q, obst1_d, obst0_q, obst0_d;
  logic valid1_q, valid1_d, valid0_q, valid0_d;
  logic [4:0] gp1_q, gp1_d, gp0_q, gp0_d;
  logic busy_q, busy_d;
  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .state(lfsr));
  assign unused_lfsr = ^lfsr[15:5];
  // request edges, draw/build sequencing and the atomic slot commit
  always_comb begin
    cand = lfsr[4:0];
    cand_ok = cand >= GAP_MIN && cand <= GAP_MAX;
    edge1 = bus.req_slot1 & ~req1_q;
    edge0 = bus.req_slot0 & ~req0_q;
    commit1 = state_q == G_COMMIT && tgt_q;
    commit0 = state_q == G_COMMIT && !tgt_q;
    mask = '0;
    for (int r = 0; r < ROWS; r++)
      mask[r] = !(r >= int'(gap_q) && r < int'(gap_q) + GAP_H);
    state_d = state_q;
    tgt_d = tgt_q;
    tries_d = tries_q;
    gap_d = gap_q;
    col_d = col_q;
    case (state_q)
      G_IDLE: begin
        state_d = pend1_q || pend0_q ? G_DRAW : G_IDLE;
        tgt_d = pend1_q;
      end
      G_DRAW: begin
        state_d = cand_ok || tries_q == TRY_W'(MAX_TRIES - 1) ? G_BUILD : G_DRAW;
        gap_d = cand_ok ? cand : GAP_FALLBACK;
        tries_d = tries_q + 1'b1;
      end
      G_BUILD: begin
        col_d = mask;
        state_d = G_COMMIT;
      end
      default: begin
        state_d = G_IDLE;
        tries_d = '0;
      end
    endcase
    req1_d = bus.req_slot1;
    req0_d = bus.req_slot0;
    pend1_d = (pend1_q | edge1) & ~commit1;
    pend0_d = (pend0_q | edge0) & ~commit0;
    obst1_d = commit1 ? {col_q, col_q} : obst1_q;
    obst0_d = commit0 ? {col_q, col_q} : obst0_q;
    valid1_d = valid1_q | commit1;
    valid0_d = valid0_q | commit0;
    gp1_d = commit1 ? gap_q : gp1_q;
    gp0_d = commit0 ? gap_q : gp0_q;
    busy_d = state_d != G_IDLE;
  end
  // all state and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= G_IDLE;
      tgt_q <= 1'b0;
      tries_q <= '0;
      gap_q <= '0;
      col_q <= '0;
      req1_q <= 1'b0;
      req0_q <= 1'b0;
      pend1_q <= 1'b0;
      pend0_q <= 1'b0;
      obst1_q <= '0;
      obst0_q <= '0;
      valid1_q <= 1'b0;
      valid0_q <= 1'b0;
      gp1_q <= '0;
      gp0_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      tries_q <= tries_d;
      gap_q <= gap_d;
      col_q <= col_d;
      req1_q <= req1_d;
      req0_q <= req0_d;
      pend1_q <= pend1_d;
      pend0_q <= pend0_d;
      obst1_q <= obst1_d;
      obst0_q <= obst0_d;
      valid1_q <= valid1_d;
      valid0_q <= valid0_d;
      gp1_q <= gp1_d;
      gp0_q <= gp0_d;
      busy_q <= busy_d;
    end
  assign bus.obst1 = obst1_q;
  assign bus.obst0 = obst0_q;
  assign bus.valid1 = valid1_q;
  assign bus.valid0 = valid0_q;
  assign bus.gap_pos1 = gp1_q;
  assign bus.gap_pos0 = gp0_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_obstacle_generator.sv
// tb_obstacle_generator: directed scenarios checked against a transaction-level model
module tb_obstacle_generator;
  import flab_pkg::*;
  localparam int NL = 8192;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  obstacle_generator_if bus();
  obstacle_generator #(.SEED(16'hACE1)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] lt [NL];
  int n = 0;
  bit m_busy = 0, m_tgt = 0, m_p1 = 0, m_p0 = 0, m_r1 = 0, m_r0 = 0, m_v1 = 0, m_v0 = 0;
  bit e1, e0, c1, c0;
  int m_commit_n = 0, m_gap = 0, m_g1 = 0, m_g0 = 0;
  pair_t m_o1 = '0, m_o0 = '0;
  int busy_rises = 0;
  bit busy_prev = 0;

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
  endfunction
  function automatic bit in_range(input int c);
    return c >= MARGIN && c <= ROWS - GAP_H - MARGIN;
  endfunction
  function automatic int cand_at(input int k);
    return int'(lt[k][4:0]);
  endfunction
  function automatic pair_t wall(input int g);
    column_t c;
    for (int r = 0; r < ROWS; r++) c[r] = (r < g || r >= g + GAP_H);
    return {c, c};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", nm, act, exp, n);
    end
  endtask

  // model: a request picks the first in-range LFSR draw (or the fallback) and commits it later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; m_busy = 0; m_tgt = 0; m_p1 = 0; m_p0 = 0; m_r1 = 0; m_r0 = 0;
      m_v1 = 0; m_v0 = 0; m_g1 = 0; m_g0 = 0; m_o1 = '0; m_o0 = '0;
    end else begin
      n++;
      e1 = bus.req_slot1 && !m_r1;
      e0 = bus.req_slot0 && !m_r0;
      m_r1 = bus.req_slot1;
      m_r0 = bus.req_slot0;
      c1 = 0;
      c0 = 0;
      if (m_busy && n == m_commit_n) begin
        m_busy = 0;
        if (m_tgt) begin c1 = 1; m_v1 = 1; m_g1 = m_gap; m_o1 = wall(m_gap); end
        else begin c0 = 1; m_v0 = 1; m_g0 = m_gap; m_o0 = wall(m_gap); end
      end else if (!m_busy && (m_p1 || m_p0)) begin
        m_busy = 1;
        m_tgt = m_p1;
        m_gap = (ROWS - GAP_H) / 2;
        m_commit_n = n + 2 + MAX_TRIES;
        for (int j = MAX_TRIES - 1; j >= 0; j--)
          if (in_range(cand_at(n + j))) begin m_gap = cand_at(n + j); m_commit_n = n + 3 + j; end
      end
      m_p1 = (m_p1 || e1) && !c1;
      m_p0 = (m_p0 || e0) && !c0;
    end
  end

  // every-cycle comparison against the model, plus busy-period counting
  always @(posedge clk) begin
    #2;
    chk("obst1", 64'(bus.obst1), 64'(m_o1));
    chk("obst0", 64'(bus.obst0), 64'(m_o0));
    chk("valid1", 64'(bus.valid1), 64'(m_v1));
    chk("valid0", 64'(bus.valid0), 64'(m_v0));
    chk("gap_pos1", 64'(bus.gap_pos1), 64'(m_g1));
    chk("gap_pos0", 64'(bus.gap_pos0), 64'(m_g0));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("lfsr", 64'(dut.u_lfsr.state_q), 64'(lt[n]));
    if (bus.busy && !busy_prev) busy_rises++;
    busy_prev = bus.busy;
  end

  task automatic at_n(input int t);
    while (n < t) @(negedge clk);
  endtask

  task automatic run_cand10();
    int n0;
    pair_t o1s, o0s;
    logic [4:0] g1s;
    logic v1s;
    n0 = -1;
    for (int k = n + 3; k < NL - 20 && n0 < 0; k++) if (cand_at(k + 1) == 10) n0 = k;
    if (n0 < 0) begin
      checks++; errors++;
      $display("FAIL cand10_search no suitable cycle");
      return;
    end
    at_n(n0 - 1);
    o1s = bus.obst1; o0s = bus.obst0; g1s = bus.gap_pos1; v1s = bus.valid1;
    bus.req_slot1 = 1'b1;
    at_n(n0 + 3);
    chk("c10_hold_obst1", 64'(bus.obst1), 64'(o1s));
    chk("c10_hold_gap1", 64'(bus.gap_pos1), 64'(g1s));
    chk("c10_hold_valid1", 64'(bus.valid1), 64'(v1s));
    chk("c10_busy", 64'(bus.busy), 64'(1));
    at_n(n0 + 4);
    chk("c10_obst1", 64'(bus.obst1), {16'h0, 24'hFF03FF, 24'hFF03FF});
    chk("c10_gap1", 64'(bus.gap_pos1), 64'(10));
    chk("c10_valid1", 64'(bus.valid1), 64'(1));
    chk("c10_obst0", 64'(bus.obst0), 64'(o0s));
    chk("c10_idle", 64'(bus.busy), 64'(0));
    bus.req_slot1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_fallback();
    int n0;
    bit bad;
    pair_t o1s, o0s;
    n0 = -1;
    for (int k = n + 3; k < NL - 20 && n0 < 0; k++) begin
      bad = 1;
      for (int j = 0; j < MAX_TRIES; j++) if (in_range(cand_at(k + 1 + j))) bad = 0;
      if (bad) n0 = k;
    end
    if (n0 < 0) begin
      checks++; errors++;
      $display("FAIL fallback_search no suitable cycle");
      return;
    end
    at_n(n0 - 1);
    o1s = bus.obst1; o0s = bus.obst0;
    bus.req_slot0 = 1'b1;
    at_n(n0 + 2 + MAX_TRIES);
    chk("fb_hold_obst0", 64'(bus.obst0), 64'(o0s));
    at_n(n0 + 3 + MAX_TRIES);
    chk("fb_obst0", 64'(bus.obst0), {16'h0, 24'hFF81FF, 24'hFF81FF});
    chk("fb_gap0", 64'(bus.gap_pos0), 64'(9));
    chk("fb_valid0", 64'(bus.valid0), 64'(1));
    chk("fb_obst1", 64'(bus.obst1), 64'(o1s));
    bus.req_slot0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0, t1, t0, r;
    lt[0] = 16'hACE1;
    for (int i = 1; i < NL; i++) lt[i] = step(lt[i-1]);
    bus.req_slot1 = 1'b0;
    bus.req_slot0 = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    at_n(1);
    chk("lfsr_pin1", 64'(dut.u_lfsr.state_q), 64'(16'hE270));
    at_n(2);
    chk("lfsr_pin2", 64'(dut.u_lfsr.state_q), 64'(16'h7138));
    at_n(3);
    chk("lfsr_pin3", 64'(dut.u_lfsr.state_q), 64'(16'h389C));
    at_n(50);
    chk("idle_obst1", 64'(bus.obst1), 64'(0));
    chk("idle_obst0", 64'(bus.obst0), 64'(0));
    chk("idle_valid", 64'({bus.valid1, bus.valid0}), 64'(0));
    chk("idle_busy", 64'(bus.busy), 64'(0));

    bus.req_slot1 = 1'b1;
    bus.req_slot0 = 1'b1;
    n0 = n + 1;
    t1 = -1;
    t0 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid1 && t1 < 0) t1 = n;
      if (bus.valid0 && t0 < 0) t0 = n;
    end
    chk("both_order", 64'(t1 >= 0 && t0 > t1), 64'(1));
    chk("both_bound", 64'(t0 >= 0 && t0 - n0 <= 2 * (3 + MAX_TRIES) + 2), 64'(1));
    chk("both_range1", 64'(bus.gap_pos1 >= 2 && bus.gap_pos1 <= 16), 64'(1));
    chk("both_range0", 64'(bus.gap_pos0 >= 2 && bus.gap_pos0 <= 16), 64'(1));
    chk("both_pat1", 64'(bus.obst1), 64'(wall(int'(bus.gap_pos1))));
    chk("both_pat0", 64'(bus.obst0), 64'(wall(int'(bus.gap_pos0))));
    bus.req_slot1 = 1'b0;
    bus.req_slot0 = 1'b0;
    repeat (3) @(negedge clk);

    run_cand10();
    run_fallback();

    r = busy_rises;
    bus.req_slot0 = 1'b1;
    repeat (100) @(negedge clk);
    chk("hold_one_gen", 64'(busy_rises - r), 64'(1));
    bus.req_slot0 = 1'b0;
    repeat (2) @(negedge clk);
    r = busy_rises;
    bus.req_slot0 = 1'b1;
    repeat (30) @(negedge clk);
    chk("rerise_one_gen", 64'(busy_rises - r), 64'(1));
    bus.req_slot0 = 1'b0;
    repeat (2) @(negedge clk);
    r = busy_rises;
    bus.req_slot0 = 1'b1;
    @(negedge clk);
    bus.req_slot0 = 1'b0;
    @(negedge clk);
    bus.req_slot0 = 1'b1;
    repeat (40) @(negedge clk);
    chk("absorb_one_gen", 64'(busy_rises - r), 64'(1));
    bus.req_slot0 = 1'b0;
    repeat (2) @(negedge clk);

    bus.req_slot1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pre_busy", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("rst_obst1", 64'(bus.obst1), 64'(0));
    chk("rst_obst0", 64'(bus.obst0), 64'(0));
    chk("rst_valid", 64'({bus.valid1, bus.valid0}), 64'(0));
    chk("rst_gaps", 64'({bus.gap_pos1, bus.gap_pos0}), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_lfsr", 64'(dut.u_lfsr.state_q), 64'(16'hACE1));
    bus.req_slot1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_cand10();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
